key_mode_ctrl: RTL and testbench

// - Consumes the debounced key level KP from the DBC debouncer and turns it into user events.
// - Classifies each press as short or long and drives the rainbow mode index and pause flag.
// - MODE and PAUSE feed the downstream RGB pattern generator.

---
 rtl/key_mode_if.sv | 29 ++
 rtl/key_mode_ctrl.sv | 159 +++++++++++++++
 tb/tb_key_mode_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/key_mode_if.sv
// ============================================================================
// Module   : key_mode_if
// Brief    : Key level in, key events plus mode/pause state out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface key_mode_if #(
  parameter int MODE_W = 3
) ();
  logic              kp;       // debounced key level, 0 = pressed
  logic              short_p;
  logic              long_p;
  logic              rep_p;
  logic [MODE_W-1:0] mode;
  logic              pause;

  modport master (
    output kp,
    input  short_p, long_p, rep_p, mode, pause
  );

  modport slave (
    input  kp,
    output short_p, long_p, rep_p, mode, pause
  );
endinterface

`default_nettype wire

// File: rtl/key_mode_ctrl.sv
// ============================================================================
// Module   : key_mode_ctrl
// Brief    : Short/long key-press classifier driving rainbow MODE and PAUSE.
//            Optional auto-repeat while held is built when KEY_REPEAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_mode_ctrl #(
  parameter int MODE_NUM   = 7,
  parameter int MODE_W     = 3,
  parameter int CNT_W      = 26,
  parameter int LONG_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 12_500_000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  key_mode_if.slave  kb
);

  if (MODE_NUM < 2 || MODE_NUM > (1 << MODE_W) || LONG_CYC < 1 || REPEAT_CYC < 1)
  begin : g_bad_params
    $error("key_mode_ctrl: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0]  LONG_LIM  = CNT_W'(LONG_CYC);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(MODE_NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HELD  = 2'd2
  } state_e;

  state_e            state_q;
  logic              kp_q;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              pause_q;
  logic              short_q;
  logic              long_q;
  logic              key_press;

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LIM = CNT_W'(REPEAT_CYC);
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_q;
`endif

  // kp_q resets low, so a key already down at reset never looks like a fresh press
  assign key_press = ~kb.kp & kp_q;

  always_comb begin
    hold_cnt_d = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
    mode_d     = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);
`ifdef KEY_REPEAT_EN
    rep_cnt_d  = rep_cnt_q + CNT_W'(1);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      kp_q       <= 1'b0;
      hold_cnt_q <= '0;
      mode_q     <= '0;
      pause_q    <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt_q  <= '0;
      rep_q      <= 1'b0;
`endif
    end else begin
      kp_q    <= kb.kp;
      short_q <= 1'b0;
      long_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_q   <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (key_press) begin
            hold_cnt_q <= CNT_W'(1);
            if (LONG_LIM <= CNT_W'(1)) begin
              state_q <= ST_HELD;
              long_q  <= 1'b1;
              pause_q <= ~pause_q;
`ifdef KEY_REPEAT_EN
              rep_cnt_q <= '0;
`endif
            end else begin
              state_q <= ST_PRESS;
            end
          end
        end

        ST_PRESS: begin
          if (kb.kp) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            short_q    <= 1'b1;
            mode_q     <= mode_d;
          end else begin
            hold_cnt_q <= hold_cnt_d;
            if (hold_cnt_d >= LONG_LIM) begin
              state_q <= ST_HELD;
              long_q  <= 1'b1;
              pause_q <= ~pause_q;
`ifdef KEY_REPEAT_EN
              rep_cnt_q <= '0;
`endif
            end
          end
        end

        ST_HELD: begin
          // The press was consumed by LONG_P; release just re-arms the detector
          if (kb.kp) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
`ifdef KEY_REPEAT_EN
            rep_cnt_q  <= '0;
`endif
          end else begin
            hold_cnt_q <= hold_cnt_d;
`ifdef KEY_REPEAT_EN
            if (rep_cnt_d >= REP_LIM) begin
              rep_cnt_q <= '0;
              rep_q     <= 1'b1;
              mode_q    <= mode_d;
            end else begin
              rep_cnt_q <= rep_cnt_d;
            end
`endif
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          hold_cnt_q <= '0;
        end
      endcase
    end
  end

  assign kb.short_p = short_q;
  assign kb.long_p  = long_q;
  assign kb.mode    = mode_q;
  assign kb.pause   = pause_q;
`ifdef KEY_REPEAT_EN
  assign kb.rep_p   = rep_q;
`else
  assign kb.rep_p   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_key_mode_ctrl.sv
// ============================================================================
// Module   : tb_key_mode_ctrl
// Brief    : Directed self-checking bench for key_mode_ctrl (LONG=8, REPEAT=4, MODES=5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_mode_ctrl;

  localparam int MODE_W = 3;

`ifdef KEY_REPEAT_EN
  localparam int HOLD_LEN      = 19;
  localparam int EXP_REP       = 2;
  localparam int MODE_AFT_LONG = 0;
`else
  localparam int HOLD_LEN      = 20;
  localparam int EXP_REP       = 0;
  localparam int MODE_AFT_LONG = 3;
`endif

  logic clk;
  logic rst_n;

  key_mode_if #(.MODE_W(MODE_W)) kb ();

  key_mode_ctrl #(
    .MODE_NUM   (5),
    .MODE_W     (MODE_W),
    .CNT_W      (8),
    .LONG_CYC   (8),
    .REPEAT_CYC (4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .kb     (kb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;
  int n_short, n_long, n_rep, n_multi, step, long_at, rep_at;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear();
    n_short = 0; n_long = 0; n_rep = 0; step = 0; long_at = 0; rep_at = 0;
  endtask

  // Drive kp for n edges; outputs are sampled 1 ns after each edge
  task automatic run(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      kb.kp = v;
      @(posedge clk);
      #1;
      step++;
      if (kb.short_p === 1'b1) n_short++;
      if (kb.long_p === 1'b1) begin n_long++; long_at = step; end
      if (kb.rep_p === 1'b1) begin n_rep++; if (rep_at == 0) rep_at = step; end
      if (int'(kb.short_p) + int'(kb.long_p) + int'(kb.rep_p) > 1) n_multi++;
    end
  endtask

  initial begin
    n_multi = 0;
    clear();
    kb.kp = 1'b1;
    rst_n = 1'b0;
    run(1'b1, 2);
    chk("reset_mode",  int'(kb.mode), 0);
    chk("reset_pause", int'(kb.pause), 0);
    chk("reset_short", int'(kb.short_p), 0);
    chk("reset_long",  int'(kb.long_p), 0);
    chk("reset_rep",   int'(kb.rep_p), 0);
    rst_n = 1'b1;
    run(1'b1, 2);

    // Short press of 3 samples
    clear();
    run(1'b0, 3);
    chk("short_none_while_held", n_short, 0);
    run(1'b1, 1);
    chk("short_pulse_latency", int'(kb.short_p), 1);
    chk("short_mode_0_to_1", int'(kb.mode), 1);
    run(1'b1, 3);
    chk("short_count", n_short, 1);
    chk("short_no_long", n_long, 0);
    chk("short_pause", int'(kb.pause), 0);

    run(1'b0, 2); run(1'b1, 2);
    run(1'b0, 2); run(1'b1, 2);
    chk("mode_at_3", int'(kb.mode), 3);

    // Five shorts from mode 3 wrap through 4,0,1,2,3
    clear();
    run(1'b0, 2); run(1'b1, 2); chk("wrap_seq_1", int'(kb.mode), 4);
    run(1'b0, 2); run(1'b1, 2); chk("wrap_seq_2", int'(kb.mode), 0);
    run(1'b0, 2); run(1'b1, 2); chk("wrap_seq_3", int'(kb.mode), 1);
    run(1'b0, 2); run(1'b1, 2); chk("wrap_seq_4", int'(kb.mode), 2);
    run(1'b0, 2); run(1'b1, 2); chk("wrap_seq_5", int'(kb.mode), 3);
    chk("wrap_short_count", n_short, 5);

    // Long hold
    clear();
    run(1'b0, HOLD_LEN);
    chk("long_count", n_long, 1);
    chk("long_latency_step", long_at, 8);
    chk("long_pause_set", int'(kb.pause), 1);
    run(1'b1, 3);
    chk("long_no_short", n_short, 0);
    chk("long_mode", int'(kb.mode), MODE_AFT_LONG);
    chk("long_rep_count", n_rep, EXP_REP);
`ifdef KEY_REPEAT_EN
    chk("rep_first_step", rep_at, 12);
`endif

    // 7-sample hold stays short
    clear();
    run(1'b0, 7);
    run(1'b1, 3);
    chk("hold7_short", n_short, 1);
    chk("hold7_no_long", n_long, 0);
    chk("hold7_mode", int'(kb.mode), (MODE_AFT_LONG + 1) % 5);

    // Single-cycle release between two presses
    clear();
    run(1'b0, 3); run(1'b1, 1); run(1'b0, 3); run(1'b1, 2);
    chk("gap1_short", n_short, 2);
    chk("gap1_no_long", n_long, 0);
    chk("gap1_mode", int'(kb.mode), (MODE_AFT_LONG + 3) % 5);
    chk("gap1_pause", int'(kb.pause), 1);

    // Key held down through reset
    rst_n = 1'b0;
    run(1'b0, 2);
    rst_n = 1'b1;
    clear();
    run(1'b0, 30);
    run(1'b1, 3);
    chk("thru_reset_short", n_short, 0);
    chk("thru_reset_long", n_long, 0);
    chk("thru_reset_rep", n_rep, 0);
    chk("thru_reset_mode", int'(kb.mode), 0);
    chk("thru_reset_pause", int'(kb.pause), 0);

    // Reset at hold cycle 5, release at cycle 10
    run(1'b0, 2); run(1'b1, 2);
    chk("pre_midreset_mode", int'(kb.mode), 1);
    clear();
    run(1'b0, 4);
    rst_n = 1'b0;
    run(1'b0, 1);
    chk("midreset_mode", int'(kb.mode), 0);
    chk("midreset_short", int'(kb.short_p), 0);
    rst_n = 1'b1;
    run(1'b0, 4);
    run(1'b1, 4);
    chk("midreset_no_short", n_short, 0);
    chk("midreset_no_long", n_long, 0);
    chk("midreset_mode_after", int'(kb.mode), 0);
    chk("midreset_pause_after", int'(kb.pause), 0);

    chk("pulses_exclusive", n_multi, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
